// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with HI/LO registers.
// Executes MULT, MULTU, DIV, DIVU and services MTHI/MTLO writes when idle.
// Optional macro MDU_FAST_MUL_EN: multiplies finish in one cycle using a
// combinational multiplier; divides keep the iterative path.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO writes accepted here
// RUN   | one shift-add / restoring shift-subtract step per cycle
// FIN   | sign correction, hi/lo update, done pulse
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_lo;   // negate product / quotient at FIN
  logic             neg_hi;   // negate remainder at FIN
  logic             dz;       // divide by zero pending
  logic [WIDTH-1:0] mcand;    // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0] acc;      // product upper half or partial remainder
  logic [WIDTH-1:0] mq;       // multiplier/product lower half or dividend/quotient

  logic             op_signed;
  logic             b_zero;
  logic             fast_mul;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_sub;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
  assign b_zero    = op[1] && (b == '0);
`ifdef MDU_FAST_MUL_EN
  assign fast_mul  = ~op[1];
  assign prod_mag  = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, mq};
`else
  assign fast_mul  = 1'b0;
  assign prod_mag  = {acc, mq};
`endif

  // One iteration step for each algorithm, plus the final sign correction.
  assign mul_sum = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign div_sh  = {acc, mq[WIDTH-1]};
  assign div_ge  = (div_sh >= {1'b0, mcand});
  assign div_sub = div_sh - {1'b0, mcand};
  assign prod    = neg_lo ? -prod_mag : prod_mag;
  assign quo     = neg_lo ? -mq : mq;
  assign rem     = neg_hi ? -acc : acc;

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; divide-by-zero and fast multiply skip RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (b_zero || fast_mul) ? FIN : RUN;
      RUN:  if (cnt == CNT_W'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath, result write-back and MTHI/MTLO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz       <= 1'b0;
      mcand    <= '0;
      acc      <= '0;
      mq       <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            neg_lo <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= op_signed & op[1] & a[WIDTH-1];
            dz     <= b_zero;
            mcand  <= op[1] ? b_mag : a_mag;
            mq     <= op[1] ? a_mag : b_mag;
            // on divide by zero the raw dividend rides in acc to become hi
            acc    <= b_zero ? a : '0;
            cnt    <= CNT_W'(WIDTH);
          end else begin
            if (hi_wr) hi <= wdata;
            if (lo_wr) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (is_div) begin
            acc <= div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
            mq  <= {mq[WIDTH-2:0], div_ge};
          end else begin
            {acc, mq} <= {mul_sum, mq[WIDTH-1:1]};
          end
        end
        FIN: begin
          cnt      <= '0;
          done     <= 1'b1;
          div_zero <= dz;
          if (dz) begin
            hi <= acc;
            lo <= '1;
          end else if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH=32) against a plain-arithmetic model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hi_wr = 1'b0;
  logic         lo_wr = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_chk = 0;
  int n_pass = 0;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic.
  function automatic void model(input logic [1:0] xop, input logic [W-1:0] xa, input logic [W-1:0] xb,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo, output logic edz);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    edz = 1'b0;
    p = '0;
    case (xop)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, xa} * {32'b0, xb};
      2'b10: begin
        if (xb == 0) begin edz = 1'b1; p = {xa, 32'hFFFF_FFFF}; end
        else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      end
      default: begin
        if (xb == 0) begin edz = 1'b1; p = {xa, 32'hFFFF_FFFF}; end
        else p = {xa % xb, xa / xb};
      end
    endcase
    ehi = p[63:32];
    elo = p[31:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] xop, input logic [W-1:0] xb);
    if (xop[1] && xb == 0) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!xop[1]) return 1;
`endif
    return W + 1;
  endfunction

  // Present a request; caller is just past a clock edge.
  task automatic issue(input logic [1:0] xop, input logic [W-1:0] xa, input logic [W-1:0] xb);
    start = 1'b1;
    op = xop;
    a = xa;
    b = xb;
  endtask

  // Let the issued request be accepted, then wait for done and check everything.
  task automatic run_wait(input string tag, input logic [1:0] xop, input logic [W-1:0] xa,
                          input logic [W-1:0] xb, input bit disturb);
    logic [W-1:0] ehi, elo, pre_hi, pre_lo;
    logic edz;
    bit hold_ok;
    int n;
    model(xop, xa, xb, ehi, elo, edz);
    pre_hi = hi;
    pre_lo = lo;
    hold_ok = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    chk({tag, "_busy_on"}, busy, 1);
    n = 0;
    while (!done && n < 100) begin
      if (hi !== pre_hi || lo !== pre_lo) hold_ok = 1'b0;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'b10; hi_wr = 1'b1; wdata = 32'h1234;
      end else if (disturb && n == 6) begin
        start = 1'b0; op = xop; hi_wr = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, exp_lat(xop, xb));
    chk({tag, "_hold"}, hold_ok, 1);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_dz"}, div_zero, edz);
    chk({tag, "_busy_off"}, busy, 0);
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;

    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); run_wait("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd5);         run_wait("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);         run_wait("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    issue(2'b11, 32'd7, 32'd2);                 run_wait("divu", 2'b11, 32'd7, 32'd2, 0);
    issue(2'b11, 32'd7, 32'd0);                 run_wait("divu_zero", 2'b11, 32'd7, 32'd0, 0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF); run_wait("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(2'b00, 32'h0001_2345, 32'hFFFF_FFB3); run_wait("mult_disturb", 2'b00, 32'h0001_2345, 32'hFFFF_FFB3, 1);

    @(posedge clk); #1;
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    chk("mthi_both", hi, 32'hA5A5_A5A5);
    chk("mtlo_both", lo, 32'hA5A5_A5A5);
    hi_wr = 1'b1; wdata = 32'h11;
    @(posedge clk); #1;
    hi_wr = 1'b0;
    chk("mthi_only_hi", hi, 32'h11);
    chk("mthi_only_lo", lo, 32'hA5A5_A5A5);
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hDEAD;
    issue(2'b11, 32'd20, 32'd3); run_wait("start_beats_mt", 2'b11, 32'd20, 32'd3, 0);

    @(posedge clk); #1;
    issue(2'b10, 32'd100, 32'd7);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_done", done, 0);
    @(posedge clk); #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_no_done", done, 0);
    end
    issue(2'b10, 32'd100, 32'd7); run_wait("after_rst", 2'b10, 32'd100, 32'd7, 0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF); run_wait("b2b_first", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    issue(2'b01, 32'd6, 32'd7);                 run_wait("b2b_second", 2'b01, 32'd6, 32'd7, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(15));
        default: ;
      endcase
      if ($urandom_range(1) == 1) begin
        @(posedge clk); #1;
        chk("rand_done_pulse", done, 0);
      end
      issue(rop, ra, rb); run_wait("rand", rop, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
